// File: rtl/mips_icache_dm.sv
// Direct-mapped, one-word-per-line, read-only instruction cache.
// The CPU fetch port is on one side and a word-read memory port is on the other.
// A hit answers one cycle after the request. A miss issues one downstream read,
// waits for mem_dvalid, fills the line and forwards the word.
// Hit and miss counters saturate instead of wrapping.

// One cache line of tag and data storage. There is no reset here; the valid
// bits are kept in the top module.
module mips_icache_line #(
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data
);

    // Capture the tag and data when this line is the fill target.
    always_ff @(posedge clk) begin
        if (we) begin
            rd_tag  <= wr_tag;
            rd_data <= wr_data;
        end
    end

endmodule

module mips_icache_dm #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         cpu_addr,
    input  logic                cpu_read_en,
    output logic [31:0]         cpu_data,
    output logic                cpu_dvalid,
    input  logic                invalidate,
    output logic [31:0]         mem_addr,
    output logic                mem_read_en,
    input  logic [31:0]         mem_data,
    input  logic                mem_dvalid,
    output logic [CNT_BITS-1:0] hit_cnt,
    output logic [CNT_BITS-1:0] miss_cnt
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    // Byte address split into its cache fields.
    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [INDEX_BITS-1:0] idx;
        logic [1:0]            off;
    } addr_t;

    state_t                    state_q, state_d;
    logic [LINES-1:0]          valid_q;
    logic [31:0]               cpu_data_q, cpu_data_d;
    logic                      cpu_dvalid_q, cpu_dvalid_d;
    logic [31:0]               mem_addr_q, mem_addr_d;
    logic                      mem_read_en_q, mem_read_en_d;
    logic [CNT_BITS-1:0]       hit_cnt_q, miss_cnt_q;
    logic                      hit_inc, miss_inc;
    logic                      line_we;
    logic                      lookup_hit;

    logic [LINES-1:0][TAG_W-1:0] line_tag;
    logic [LINES-1:0][31:0]      line_data;

    addr_t req_a;
    addr_t fill_a;

    // The CPU address is used only in IDLE. During FILL, mem_addr_q holds the
    // latched address, so it is also the fill target. Byte-offset bits do not
    // select anything.
    assign req_a  = addr_t'(cpu_addr);
    assign fill_a = addr_t'(mem_addr_q);

    logic unused_off;
    assign unused_off = ^{req_a.off, fill_a.off};

    // A same-edge invalidate makes the lookup a miss, even when the line is valid.
    assign lookup_hit = valid_q[req_a.idx]
                     && (line_tag[req_a.idx] == req_a.tag)
                     && !invalidate;

    // Line storage array. Only the line selected by the latched index is written.
    for (genvar g = 0; g < LINES; g++) begin : g_line
        mips_icache_line #(
            .TAG_W (TAG_W),
            .DATA_W(32)
        ) u_line (
            .clk    (clk),
            .we     (line_we && (fill_a.idx == INDEX_BITS'(g))),
            .wr_tag (fill_a.tag),
            .wr_data(mem_data),
            .rd_tag (line_tag[g]),
            .rd_data(line_data[g])
        );
    end

    // Next-state and next-output logic. Every output comes straight from a register.
    always_comb begin
        state_d       = state_q;
        cpu_data_d    = cpu_data_q;
        cpu_dvalid_d  = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_read_en_d = mem_read_en_q;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        line_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_read_en) begin
                    if (lookup_hit) begin
                        cpu_data_d   = line_data[req_a.idx];
                        cpu_dvalid_d = 1'b1;
                        hit_inc      = 1'b1;
                        state_d      = RESP;
                    end else begin
                        mem_addr_d    = {cpu_addr[31:2], 2'b00};
                        mem_read_en_d = 1'b1;
                        miss_inc      = 1'b1;
                        state_d       = FILL;
                    end
                end
            end
            FILL: begin
                mem_read_en_d = 1'b1;
                if (mem_dvalid) begin
                    // An invalidate on this edge cancels the line write, but the
                    // word is still returned to the CPU.
                    line_we       = !invalidate;
                    cpu_data_d    = mem_data;
                    cpu_dvalid_d  = 1'b1;
                    mem_read_en_d = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d       = IDLE;
                mem_read_en_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs. A reset during FILL drops the request, and
    // no line is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cpu_data_q    <= '0;
            cpu_dvalid_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_read_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_data_q    <= cpu_data_d;
            cpu_dvalid_q  <= cpu_dvalid_d;
            mem_addr_q    <= mem_addr_d;
            mem_read_en_q <= mem_read_en_d;
        end
    end

    // Valid bits. An invalidate clears every valid bit and takes priority over a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (invalidate) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[fill_a.idx] <= 1'b1;
        end
    end

    // Hit and miss counters. Each holds at its maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + 1'b1;
            if (miss_inc && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign cpu_data    = cpu_data_q;
    assign cpu_dvalid  = cpu_dvalid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_read_en = mem_read_en_q;
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_mips_icache_dm.sv
// Bench for mips_icache_dm. The memory answers one cycle after it sees a request.
// Expected values come from a plain model: a valid/tag table with one entry per
// index, and hit/miss tallies that saturate.
module tb_mips_icache_dm;

    localparam int IB  = 4;
    localparam int CB  = 4;
    localparam int NL  = 1 << IB;
    localparam int TW  = 30 - IB;
    localparam int MAXC = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   cpu_addr;
    logic          cpu_read_en;
    logic [31:0]   cpu_data;
    logic          cpu_dvalid;
    logic          invalidate;
    logic [31:0]   mem_addr;
    logic          mem_read_en;
    logic [31:0]   mem_data;
    logic          mem_dvalid;
    logic [CB-1:0] hit_cnt;
    logic [CB-1:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_valid [NL];
    logic [TW-1:0] m_tag [NL];
    int          m_hits;
    int          m_miss;

    mips_icache_dm #(.INDEX_BITS(IB), .CNT_BITS(CB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_read_en(cpu_read_en),
        .cpu_data   (cpu_data),
        .cpu_dvalid (cpu_dvalid),
        .invalidate (invalidate),
        .mem_addr   (mem_addr),
        .mem_read_en(mem_read_en),
        .mem_data   (mem_data),
        .mem_dvalid (mem_dvalid),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10)      return 32'hDEADBEEF;
        else if (a == 32'h50) return 32'h12345678;
        else                  return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch. inv_req raises invalidate on the request edge. inv_fill raises
    // it on the edge where mem_dvalid is sampled.
    task automatic do_read(input logic [31:0] a, input bit inv_req, input bit inv_fill);
        int            idx;
        logic [TW-1:0] tg;
        bit            exp_h;
        logic [31:0]   exp_d;
        idx   = int'(a[IB+1:2]);
        tg    = a[31:IB+2];
        if (inv_req) model_clear();
        exp_h = m_valid[idx] && (m_tag[idx] == tg);
        exp_d = mem_word({a[31:2], 2'b00});
        @(negedge clk);
        cpu_addr    = a;
        cpu_read_en = 1'b1;
        invalidate  = inv_req;
        @(negedge clk);
        invalidate = 1'b0;
        chk("first_dvalid", {31'b0, cpu_dvalid}, {31'b0, exp_h});
        if (exp_h) begin
            m_hits = sat(m_hits + 1);
            chk("hit_data", cpu_data, exp_d);
            chk("hit_no_mem", {31'b0, mem_read_en}, 32'd0);
        end else begin
            m_miss = sat(m_miss + 1);
            chk("miss_req", {31'b0, mem_read_en}, 32'd1);
            chk("miss_addr", mem_addr, {a[31:2], 2'b00});
            mem_dvalid = 1'b1;
            mem_data   = mem_word(mem_addr);
            invalidate = inv_fill;
            @(negedge clk);
            mem_dvalid = 1'b0;
            invalidate = 1'b0;
            mem_data   = $urandom;
            chk("fill_dvalid", {31'b0, cpu_dvalid}, 32'd1);
            chk("fill_data", cpu_data, exp_d);
            chk("fill_req_drop", {31'b0, mem_read_en}, 32'd0);
            if (inv_fill) model_clear();
            else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end
        chk("hit_cnt", {28'b0, hit_cnt}, 32'(m_hits));
        chk("miss_cnt", {28'b0, miss_cnt}, 32'(m_miss));
        cpu_read_en = 1'b0;
        @(negedge clk);
        chk("dvalid_pulse_end", {31'b0, cpu_dvalid}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cpu_addr    = '0;
        cpu_read_en = 1'b0;
        invalidate  = 1'b0;
        mem_data    = '0;
        mem_dvalid  = 1'b0;
        m_hits      = 0;
        m_miss      = 0;
        model_clear();
        #12;
        chk("rst_dvalid", {31'b0, cpu_dvalid}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_read_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_cpu_data", cpu_data, 32'd0);
        chk("rst_counts", {hit_cnt, miss_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: cold miss on 0x10.
        do_read(32'h10, 1'b0, 1'b0);
        // Test 2: the same address now hits.
        do_read(32'h10, 1'b0, 1'b0);
        chk("t2_hits", {28'b0, hit_cnt}, 32'd1);
        // Test 3: 0x50 maps to the same index and evicts 0x10.
        do_read(32'h50, 1'b0, 1'b0);
        do_read(32'h10, 1'b0, 1'b0);
        chk("t3_miss_cnt", {28'b0, miss_cnt}, 32'd3);
        // Test 4: invalidate during the fill cancels the line write.
        do_read(32'h50, 1'b0, 1'b0);
        do_read(32'h10, 1'b0, 1'b1);
        do_read(32'h10, 1'b0, 1'b0);
        // An invalidate on the lookup edge turns a hit into a miss.
        do_read(32'h10, 1'b1, 1'b0);

        // mem_dvalid is ignored outside FILL.
        @(negedge clk);
        mem_dvalid = 1'b1;
        mem_data   = 32'hBADC0DE5;
        @(negedge clk);
        mem_dvalid = 1'b0;
        chk("stray_dvalid", {31'b0, cpu_dvalid}, 32'd0);
        chk("stray_req", {31'b0, mem_read_en}, 32'd0);
        do_read(32'h10, 1'b0, 1'b0);

        // Test 5: reset during FILL.
        @(negedge clk);
        cpu_addr    = 32'h90;
        cpu_read_en = 1'b1;
        @(negedge clk);
        chk("t5_in_fill", {31'b0, mem_read_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_req_clr", {31'b0, mem_read_en}, 32'd0);
        chk("t5_dvalid_clr", {31'b0, cpu_dvalid}, 32'd0);
        chk("t5_cnt_clr", {hit_cnt, miss_cnt}, 32'd0);
        cpu_read_en = 1'b0;
        model_clear();
        m_hits = 0;
        m_miss = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_read(32'h10, 1'b0, 1'b0);
        // The abandoned fill must not leave 0x90 cached.
        do_read(32'h90, 1'b0, 1'b0);

        // Test 6: the byte offset is ignored.
        do_read(32'h13, 1'b0, 1'b0);
        do_read(32'h10, 1'b0, 1'b0);

        // Randomised traffic over a small address pool, so hits and evictions both occur.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 2) << (IB + 2)) | ($urandom_range(0, 7) << 2)
              | $urandom_range(0, 3);
            do_read(a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
        end

        // Drive both counters into saturation.
        for (int n = 0; n < 20; n++) do_read(32'h1000 + (n << (IB + 2)), 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) do_read(32'h1000 + (19 << (IB + 2)), 1'b0, 1'b0);
        chk("sat_miss", {28'b0, miss_cnt}, MAXC);
        chk("sat_hit", {28'b0, hit_cnt}, MAXC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
